cvxif_copro_resp: RTL and testbench
===================================

CVXIF_COPRO_RESP -- requirements
Module: cvxif_copro_resp

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand and result width in bits.
REQ-002 Parameter ID_W, default 3, SHALL set the transaction id width (8 scoreboard entries).
REQ-003 Parameter FIFO_DEPTH, default 2, SHALL set the result buffer depth (power of two, at least 2).
REQ-004 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  SHALL be the synchronous, active-high reset.
REQ-006 issue_valid_i  in  1  SHALL flag an offloaded instruction from the core.
REQ-007 issue_ready_o  out  1  SHALL flag that the responder can take an issue this cycle.
REQ-008 issue_instr_i  in  32  SHALL carry the raw instruction word.
REQ-009 issue_id_i  in  ID_W  SHALL carry the transaction id.
REQ-010 issue_rs1_i, issue_rs2_i  in  XLEN each  SHALL carry the source operands.
REQ-011 issue_accept_o, issue_writeback_o  out  1 each  SHALL be valid in the issue handshake cycle.
REQ-012 result_valid_o / result_ready_i  out / in  1 each  SHALL form the result handshake.
REQ-013 result_id_o  out  ID_W, result_data_o  out  XLEN, result_rd_o  out  5, result_we_o  out  1  SHALL carry the result fields.
REQ-014 flush_i  in  1  SHALL request that all in-flight and buffered work is discarded.

Function
REQ-015 Decode SHALL be purely combinational on issue_instr_i.
- Accepted: opcode 7'b0001011, funct7 = 0, and funct3 in {000 MUL, 001 ABSDIFF, 010 MINU}.
- Anything else: not accepted.
REQ-016 An issue handshake SHALL occur when issue_valid_i and issue_ready_o are both 1.
- Accepted issue: issue_accept_o = issue_writeback_o = 1.
- Not accepted: both 0, no state change, no result produced.
REQ-017 Operations SHALL be, all modulo 2^XLEN:
- MUL: low XLEN bits of unsigned rs1 times rs2.
- ABSDIFF: absolute value of (rs1 minus rs2), operands treated as unsigned.
- MINU: unsigned minimum of rs1 and rs2.
REQ-018 The FSM SHALL have three states, IDLE, EXEC and HOLD.
- IDLE to EXEC on an accepted handshake; operands, id and rd (instr[11:7]) are latched.
- EXEC to IDLE after one cycle, pushing the result, if the FIFO is not full.
- EXEC to HOLD if the FIFO is full.
- HOLD to IDLE on the cycle the FIFO frees a slot, pushing then.
REQ-019 issue_ready_o SHALL be 1 only in IDLE with flush_i = 0.
- Throughput: at most one accepted instruction per 2 cycles.
- A non-accepted instruction completes its handshake in IDLE without leaving IDLE.
REQ-020 Latency: accepted handshake in cycle N SHALL give result_valid_o = 1 at cycle N+2 when the FIFO was empty.
REQ-021 The FIFO SHALL be first-in first-out.
- result_valid_o = FIFO not empty.
- Result fields come from the FIFO head.
- result_we_o = 1 for every result.
REQ-022 A simultaneous push and pop on a full FIFO SHALL be allowed; occupancy is unchanged and no data is lost.
- The HOLD-to-IDLE push counts as such a push.
REQ-023 Result fields SHALL stay stable while result_valid_o = 1 and result_ready_i = 0.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 flush_i = 1 SHALL, on the next edge:
- empty the FIFO;
- return the FSM to IDLE, dropping any EXEC or HOLD operation;
- block any issue or push in the flush cycle;
- leave any pop in the flush cycle with no effect beyond the clear.

Reset
REQ-026 With rst_i = 1 at an edge, the responder SHALL clear the FSM to IDLE and the FIFO to empty, and after that edge drive:
- result_valid_o = 0;
- result_id_o = 0, result_data_o = 0, result_rd_o = 0, result_we_o = 0;
- issue_ready_o = 1 once rst_i = 0.
REQ-027 Reset asserted mid-operation SHALL discard all pending work, with no result emitted afterwards.
REQ-028 issue_ready_o SHALL be 0 while rst_i = 1.

Configuration
REQ-029 Macro CVXIF_COPRO_MUL_EN defined: MUL (funct3 000) SHALL be decoded and implemented.
REQ-030 Macro undefined: funct3 000 SHALL be not accepted, and no multiplier SHALL be instantiated.

Verification
REQ-031 ABSDIFF, rs1=5, rs2=9, id=3, rd=7, result_ready_i=1 -> cycle N+2: result_valid_o=1, data=4, id=3, rd=7, we=1.
REQ-032 MUL (macro defined), rs1=0xFFFFFFFF, rs2=2 -> data=0xFFFFFFFE; with the macro undefined -> issue_accept_o=0 and no result.
REQ-033 result_ready_i=0, three back-to-back MINU issues -> two results buffered, FSM holds the third in HOLD with issue_ready_o=0; then one pop -> third result is pushed and order is preserved by id.
REQ-034 Instruction word 0x00000033 (ADD) -> handshake completes with accept=0 and writeback=0, FSM stays in IDLE.
REQ-035 flush_i pulsed while the FIFO is full and EXEC is busy -> next cycle result_valid_o=0, FSM in IDLE, issue_ready_o=1.
REQ-036 rst_i asserted during EXEC -> no result is ever emitted and all outputs are at their reset values.

Source files
------------

// File: rtl/cvxif_copro_resp_if.sv
// Issue and result handshake bundle between a core and the cvxif_copro_resp responder.
// The core drives the slave inputs through the master modport.
interface cvxif_copro_resp_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 3
);
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [31:0]     issue_instr_i;
  logic [ID_W-1:0] issue_id_i;
  logic [XLEN-1:0] issue_rs1_i;
  logic [XLEN-1:0] issue_rs2_i;
  logic            issue_accept_o;
  logic            issue_writeback_o;
  logic            result_valid_o;
  logic            result_ready_i;
  logic [ID_W-1:0] result_id_o;
  logic [XLEN-1:0] result_data_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i, result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );
endinterface

// File: rtl/cvxif_copro_resp.sv
// Custom-opcode coprocessor responder: decodes ABSDIFF/MINU (and MUL when CVXIF_COPRO_MUL_EN
// is defined), executes in one cycle and returns results in order through a small FIFO.
module cvxif_copro_resp #(
  parameter int XLEN       = 32,
  parameter int ID_W       = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  cvxif_copro_resp_if.slave  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [1:0]      op_q;
  logic [ID_W-1:0] id_q;
  logic [4:0]      rd_q;
  entry_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]      funct3;
  logic            op_legal, dec_ok, handshake, accept, push, pop, full, empty;
  logic [XLEN-1:0] alu_res;

  assign funct3 = bus.issue_instr_i[14:12];

  always_comb begin
    op_legal = (funct3 == 3'b001) || (funct3 == 3'b010);
`ifdef CVXIF_COPRO_MUL_EN
    if (funct3 == 3'b000) op_legal = 1'b1;
`endif
  end

  assign dec_ok = (bus.issue_instr_i[6:0] == 7'b0001011) &&
                  (bus.issue_instr_i[31:25] == 7'd0) && op_legal;

  assign bus.issue_ready_o     = (state_q == IDLE) && !flush_i && !rst_i;
  assign handshake             = bus.issue_valid_i && bus.issue_ready_o;
  assign accept                = handshake && dec_ok;
  assign bus.issue_accept_o    = accept;
  assign bus.issue_writeback_o = accept;

  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  // A pop in a flush cycle is swallowed by the clear.
  assign pop   = !empty && bus.result_ready_i && !flush_i;

  always_comb begin
    alu_res = '0;
    case (op_q)
`ifdef CVXIF_COPRO_MUL_EN
      2'b00:   alu_res = rs1_q * rs2_q;
`endif
      2'b01:   alu_res = (rs1_q >= rs2_q) ? (rs1_q - rs2_q) : (rs2_q - rs1_q);
      2'b10:   alu_res = (rs1_q < rs2_q) ? rs1_q : rs2_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
        if (!full) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      // Pushing on a full FIFO is safe when the head leaves in the same cycle.
      HOLD: begin
        if (!full || pop) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PTR_W'(1);
        if (pop)  rptr_q <= rptr_q + PTR_W'(1);
        cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      rs1_q <= bus.issue_rs1_i;
      rs2_q <= bus.issue_rs2_i;
      op_q  <= funct3[1:0];
      id_q  <= bus.issue_id_i;
      rd_q  <= bus.issue_instr_i[11:7];
    end
    if (push && !flush_i && !rst_i) begin
      mem_q[wptr_q] <= '{id: id_q, rd: rd_q, data: alu_res};
    end
  end

  assign bus.result_valid_o = !empty;
  assign bus.result_we_o    = !empty;
  assign bus.result_id_o    = empty ? '0 : mem_q[rptr_q].id;
  assign bus.result_rd_o    = empty ? '0 : mem_q[rptr_q].rd;
  assign bus.result_data_o  = empty ? '0 : mem_q[rptr_q].data;
endmodule

// File: tb/tb_cvxif_copro_resp.sv
// Bench for cvxif_copro_resp: directed literal scenarios followed by random traffic, all
// checked every cycle against a queue-based model of the responder.
module tb_cvxif_copro_resp;
  localparam int XLEN = 32;
  localparam int ID_W = 3;
  localparam int D    = 2;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } res_t;

  logic clk, rst, flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  cvxif_copro_resp_if #(.XLEN(XLEN), .ID_W(ID_W)) bus ();

  cvxif_copro_resp #(.XLEN(XLEN), .ID_W(ID_W), .FIFO_DEPTH(D)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd);
    mk_instr = {f7, 5'd2, 5'd1, f3, rd, 7'b0001011};
  endfunction

  // ---------------- behavioural model ----------------
  function automatic bit legal(input logic [31:0] ins);
    bit ok;
    ok = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd2);
`ifdef CVXIF_COPRO_MUL_EN
    if (ins[14:12] == 3'd0) ok = 1;
`endif
    return (ins[6:0] == 7'h0B) && (ins[31:25] == 0) && ok;
  endfunction

  function automatic logic [31:0] compute(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (f3)
      3'd0:    return p[31:0];
      3'd1:    return (a > b) ? a - b : b - a;
      default: return (a < b) ? a : b;
    endcase
  endfunction

  res_t q[$];
  res_t pending;
  int   stage = 0;   // 0 idle, 1 computing, 2 waiting for room
  bit   model_live = 0;

  always @(posedge clk) begin
    bit pop, do_push;
    if (rst || flush) begin
      q.delete();
      stage = 0;
      if (rst) model_live = 1;
    end else begin
      pop     = (q.size() > 0) && bus.result_ready_i;
      do_push = 0;
      if (stage == 1) begin
        if (q.size() < D) begin do_push = 1; stage = 0; end
        else stage = 2;
      end else if (stage == 2) begin
        if (q.size() < D || pop) begin do_push = 1; stage = 0; end
      end else if (bus.issue_valid_i && legal(bus.issue_instr_i)) begin
        pending.id   = bus.issue_id_i;
        pending.rd   = bus.issue_instr_i[11:7];
        pending.data = compute(bus.issue_instr_i[14:12], bus.issue_rs1_i, bus.issue_rs2_i);
        stage = 1;
      end
      if (pop) void'(q.pop_front());
      if (do_push) q.push_back(pending);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit exp_ready, exp_acc;
    if (model_live) begin
      exp_ready = !rst && !flush && (stage == 0);
      chk("issue_ready", bus.issue_ready_o, exp_ready);
      if (bus.issue_valid_i && exp_ready) begin
        exp_acc = legal(bus.issue_instr_i);
        chk("issue_accept", bus.issue_accept_o, exp_acc);
        chk("issue_writeback", bus.issue_writeback_o, exp_acc);
      end
      chk("result_valid", bus.result_valid_o, q.size() > 0);
      if (q.size() > 0) begin
        chk("result_id", bus.result_id_o, q[0].id);
        chk("result_rd", bus.result_rd_o, q[0].rd);
        chk("result_data", bus.result_data_o, q[0].data);
        chk("result_we", bus.result_we_o, 1);
      end else begin
        chk("idle_fields", {bus.result_id_o, bus.result_rd_o, bus.result_data_o, bus.result_we_o}, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [ID_W-1:0] id, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    bus.issue_valid_i = 1'b1;
    bus.issue_instr_i = mk_instr(7'd0, f3, rd);
    bus.issue_id_i    = id;
    bus.issue_rs1_i   = a;
    bus.issue_rs2_i   = b;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 7);
      1:       return 32'hFFFF_FFFF - $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] f3;
    int sel, bias;
    rst = 1'b1; flush = 1'b0;
    bus.issue_valid_i = 0; bus.issue_instr_i = 0; bus.issue_id_i = 0;
    bus.issue_rs1_i = 0; bus.issue_rs2_i = 0; bus.result_ready_i = 0;
    step(); step();
    #5 chk("ready_in_reset", bus.issue_ready_o, 0);
    step(); rst = 1'b0;
    #5 chk("ready_after_reset", bus.issue_ready_o, 1);
    chk("valid_after_reset", bus.result_valid_o, 0);
    chk("data_after_reset", bus.result_data_o, 0);

    // ABSDIFF 5,9 -> 4 two cycles after the handshake
    step(); issue(3'd1, 3, 7, 5, 9); bus.result_ready_i = 1;
    #5 chk("absdiff_accept", bus.issue_accept_o, 1);
    step(); bus.issue_valid_i = 0;
    #5 chk("absdiff_n1_valid", bus.result_valid_o, 0);
    step();
    #5 chk("absdiff_n2_valid", bus.result_valid_o, 1);
    chk("absdiff_data", bus.result_data_o, 4);
    chk("absdiff_id", bus.result_id_o, 3);
    chk("absdiff_rd", bus.result_rd_o, 7);
    chk("absdiff_we", bus.result_we_o, 1);

    // ADD is refused but the handshake still completes
    step(); bus.issue_valid_i = 1; bus.issue_instr_i = 32'h0000_0033;
    #5 chk("add_accept", bus.issue_accept_o, 0);
    chk("add_wb", bus.issue_writeback_o, 0);
    step(); bus.issue_valid_i = 0;
    #5 chk("add_stays_idle", bus.issue_ready_o, 1);

    // MUL wraps modulo 2^32 when built in, otherwise refused
    step(); issue(3'd0, 5, 1, 32'hFFFF_FFFF, 2);
`ifdef CVXIF_COPRO_MUL_EN
    #5 chk("mul_accept", bus.issue_accept_o, 1);
`else
    #5 chk("mul_refused", bus.issue_accept_o, 0);
`endif
    step(); bus.issue_valid_i = 0;
    step();
`ifdef CVXIF_COPRO_MUL_EN
    #5 chk("mul_data", bus.result_data_o, 32'hFFFF_FFFE);
`else
    #5 chk("mul_no_result", bus.result_valid_o, 0);
`endif
    step();

    // Three MINU with a stalled consumer: two buffered, third parked
    bus.result_ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      step(); issue(3'd2, 3'(k + 1), 5'(k + 8), 32'(10 + k), 20);
      step(); bus.issue_valid_i = 0;
    end
    step();
    #5 chk("hold_ready", bus.issue_ready_o, 0);
    chk("hold_head_id", bus.result_id_o, 1);
    chk("hold_head_data", bus.result_data_o, 10);
    bus.result_ready_i = 1;
    step();
    #5 chk("order_id2", bus.result_id_o, 2);
    chk("order_data2", bus.result_data_o, 11);
    step();
    #5 chk("order_id3", bus.result_id_o, 3);
    chk("order_data3", bus.result_data_o, 12);
    step();
    #5 chk("order_drained", bus.result_valid_o, 0);

    // Flush with a full FIFO and an operation in flight
    bus.result_ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      step(); issue(3'd1, 3'(k + 4), 5'(k), 32'(k), 100);
      step(); bus.issue_valid_i = 0;
      if (k == 2) flush = 1;
    end
    step(); flush = 0;
    #5 chk("flush_valid", bus.result_valid_o, 0);
    chk("flush_ready", bus.issue_ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      #5 chk("flush_no_result", bus.result_valid_o, 0);
    end

    // Reset while an operation is executing
    bus.result_ready_i = 1;
    step(); issue(3'd2, 6, 9, 33, 44);
    step(); bus.issue_valid_i = 0; rst = 1;
    step(); rst = 0;
    #5 chk("rst_exec_ready", bus.issue_ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      #5 chk("rst_exec_no_result", bus.result_valid_o, 0);
    end

    // Random traffic
    bias = 3;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (c % 64 == 0) bias = $urandom_range(0, 4);
      sel = $urandom_range(0, 7);
      f3 = 3'($urandom_range(0, 2));
      bus.issue_valid_i = ($urandom_range(0, 3) != 0);
      bus.issue_id_i    = 3'($urandom);
      bus.issue_rs1_i   = rand_op();
      bus.issue_rs2_i   = rand_op();
      case (sel)
        0, 1, 2, 3: bus.issue_instr_i = mk_instr(7'd0, f3, 5'($urandom));
        4:          bus.issue_instr_i = mk_instr(7'd0, 3'd3 + 3'($urandom_range(0, 4)), 5'($urandom));
        5:          bus.issue_instr_i = mk_instr(7'($urandom_range(1, 127)), f3, 5'($urandom));
        default:    bus.issue_instr_i = 32'h0000_0033 | {20'd0, 5'($urandom), 7'd0};
      endcase
      bus.result_ready_i = ($urandom_range(0, 3) < bias);
      flush = ($urandom_range(0, 79) == 0);
      rst   = ($urandom_range(0, 599) == 0);
    end
    step();
    bus.issue_valid_i = 0; flush = 0; rst = 0;
    step(); step();
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
